fb_scanout: RTL and testbench
=============================

# fb_scanout

Read side of the double-buffered framebuffer. Consumes the flat packed frame vector (pixel (x,y) at bits `[(y*WIDTH+x)*PIXEL_SIZE +: PIXEL_SIZE]`) and rasters it out as a VGA-style pixel stream with hsync, vsync and data-enable. It also tells the frame writer when a buffer swap is safe, via a req/ack handshake at the start of vertical blanking.

## Interface
- `WIDTH`, 16: active pixels per line.
- `HEIGHT`, 12: active lines per frame.
- `PIXEL_SIZE`, 3: bits per pixel.
- `H_FP`, `H_SYNC`, `H_BP`, 2 / 4 / 2: horizontal front porch, sync and back porch, in clocks.
- `V_FP`, `V_SYNC`, `V_BP`, 1 / 2 / 1: vertical front porch, sync and back porch, in lines.
- `SYNC_ACTIVE_LOW`, 1: 1 means hsync and vsync are driven low when asserted.
- `clk`  in  1  pixel clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `packed_buffer`  in  WIDTH\*HEIGHT\*PIXEL_SIZE  frame currently selected by the writer.
- `swap_req`  in  1  level; writer requests a buffer swap.
- `swap_ack`  out  1  one-cycle pulse; swap is safe now.
- `pixel`  out  PIXEL_SIZE  pixel data; 0 outside the active area.
- `de`  out  1  active-video enable.
- `hsync`  out  1  horizontal sync.
- `vsync`  out  1  vertical sync.
- `frame_start`  out  1  one-cycle pulse on pixel (0,0).

## Operation
- Derived constants:
  - H_TOTAL = WIDTH+H_FP+H_SYNC+H_BP.
  - V_TOTAL = HEIGHT+V_FP+V_SYNC+V_BP.
- Counter widths:
  - h_cnt is $clog2(H_TOTAL) bits; v_cnt is $clog2(V_TOTAL) bits.
  - Pixel index arithmetic uses $clog2(WIDTH\*HEIGHT\*PIXEL_SIZE)+1 bits, with no truncation.
- h_cnt increments every clock and wraps H_TOTAL-1 → 0.
- v_cnt increments when h_cnt wraps and itself wraps V_TOTAL-1 → 0.
- Active area: h_cnt<WIDTH and v_cnt<HEIGHT.
  - de=1.
  - pixel = the packed slice at index v_cnt\*WIDTH+h_cnt.
- hsync is asserted for WIDTH+H_FP ≤ h_cnt < WIDTH+H_FP+H_SYNC, on every line including blanking lines.
- vsync is asserted for HEIGHT+V_FP ≤ v_cnt < HEIGHT+V_FP+V_SYNC, for whole lines.
- frame_start pulses when the counters are at (0,0).
- Swap handshake:
  - swap_ack pulses for exactly one cycle when the counters are at (h=0, v=HEIGHT), i.e. the first blanking cycle, and only if swap_req=1 in that cycle.
  - The writer swaps its buffer on swap_ack and drops swap_req.
  - If swap_req rises after (0,HEIGHT), it waits until the next frame's (0,HEIGHT).
  - At most one ack is issued per frame.
  - A swap_req held high continuously produces one ack per frame.
- packed_buffer is sampled combinationally each active cycle. The writer must keep the selected buffer stable outside blanking.

## Timing
- Every output is registered. Outputs in cycle n+1 reflect the counter values of cycle n, so pixel latency is 1 clock.
- Reset state (asynchronous):
  - h_cnt=v_cnt=0.
  - pixel=0, de=0, swap_ack=0, frame_start=0.
  - hsync and vsync at their inactive level (1 when SYNC_ACTIVE_LOW=1).
- After reset is released, the first rising edge registers the outputs for (0,0): frame_start=1, de=1, pixel=slice 0.
- Reset asserted mid-frame:
  - Outputs return to reset values immediately.
  - Any pending ack is lost.
  - The raster restarts at (0,0).
- The frame period is H_TOTAL\*V_TOTAL clocks; with the defaults this is 24\*16 = 384.
- Simultaneous rise of swap_req with the counters at (0,HEIGHT): the ack is issued on the next edge.

## Structure
- Shared constants go in the common defs include, not in this block:
  - `WIDTH`, `HEIGHT`, `PIXEL_SIZE`, `PACKED_SIZE`.
  - Default porch and sync values.
- Sub-module `vga_timing_gen` holds:
  - the h/v counters and the active, hsync, vsync and (0,HEIGHT) strobes;
  - all outputs unregistered.
- `fb_scanout` holds the pixel mux, the output registers and the swap handshake.

## Test plan
- **Reset values:** hold reset high → pixel=0, de=0, hsync=vsync=1, swap_ack=0, frame_start=0. Assert reset again at frame cycle 200 → same values immediately, and frame_start 1 clock after release.
- **Raster order:** load packed_buffer with pixel i = i mod 8.
  - Line 0 → pixel sequence 0,1,…,7,0,…,7 with de=1 for 16 clocks, then de=0 and pixel=0 for 8 clocks.
  - Line 1 starts with pixel 16 mod 8 = 0.
- **Horizontal sync:** hsync low exactly for output cycles corresponding to h=18..21 (4 clocks) on every line; period 24 clocks.
- **Vertical sync:**
  - vsync low for lines 13–14, i.e. 48 clocks starting at frame cycle 13\*24.
  - de=0 for lines 12–15.
  - frame_start period 384 clocks.
- **Swap handshake, early request:** raise swap_req at line 5 → one swap_ack pulse at the output of (0,12); drop req; no ack in the next frame.
- **Swap handshake, late request:** raise swap_req at (3,12) → no ack this frame; ack at (0,12) of the next frame. Hold req high for 3 frames → exactly 3 acks, 384 clocks apart.

Source files
------------

// File: rtl/fb_scanout_pkg.sv
// Shared framebuffer geometry, default video timing and sync polarity helper.
package fb_scanout_pkg;

    localparam int unsigned WIDTH       = 16;
    localparam int unsigned HEIGHT      = 12;
    localparam int unsigned PIXEL_SIZE  = 3;
    localparam int unsigned PACKED_SIZE = WIDTH * HEIGHT * PIXEL_SIZE;

    localparam int unsigned H_FP   = 2;
    localparam int unsigned H_SYNC = 4;
    localparam int unsigned H_BP   = 2;
    localparam int unsigned V_FP   = 1;
    localparam int unsigned V_SYNC = 2;
    localparam int unsigned V_BP   = 1;

    // Maps a logical "sync asserted" flag onto the pin level.
    function automatic logic sync_level(input logic asserted, input bit active_low);
        return asserted ^ active_low;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters plus combinational active/sync/strobe decodes for fb_scanout.
module vga_timing_gen #(
    parameter int unsigned WIDTH  = fb_scanout_pkg::WIDTH,
    parameter int unsigned HEIGHT = fb_scanout_pkg::HEIGHT,
    parameter int unsigned H_FP   = fb_scanout_pkg::H_FP,
    parameter int unsigned H_SYNC = fb_scanout_pkg::H_SYNC,
    parameter int unsigned H_BP   = fb_scanout_pkg::H_BP,
    parameter int unsigned V_FP   = fb_scanout_pkg::V_FP,
    parameter int unsigned V_SYNC = fb_scanout_pkg::V_SYNC,
    parameter int unsigned V_BP   = fb_scanout_pkg::V_BP,
    localparam int unsigned H_TOTAL = WIDTH + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = HEIGHT + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          active,
    output logic          hs_on,
    output logic          vs_on,
    output logic          frame_origin,
    output logic          blank_start
);

    logic [31:0] h32, v32;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (32'(h_cnt) == H_TOTAL - 1) begin
            h_cnt <= '0;
            v_cnt <= (32'(v_cnt) == V_TOTAL - 1) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Compare in 32 bits so sync windows ending at the total never truncate.
    always_comb begin
        h32          = 32'(h_cnt);
        v32          = 32'(v_cnt);
        active       = (h32 < WIDTH) && (v32 < HEIGHT);
        hs_on        = (h32 >= WIDTH + H_FP) && (h32 < WIDTH + H_FP + H_SYNC);
        vs_on        = (v32 >= HEIGHT + V_FP) && (v32 < HEIGHT + V_FP + V_SYNC);
        frame_origin = (h32 == 0) && (v32 == 0);
        blank_start  = (h32 == 0) && (v32 == HEIGHT);
    end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer read side: rasters the packed frame out with registered VGA-style
// outputs and acks buffer swaps at the first vertical-blanking cycle.
module fb_scanout #(
    parameter int unsigned WIDTH      = fb_scanout_pkg::WIDTH,
    parameter int unsigned HEIGHT     = fb_scanout_pkg::HEIGHT,
    parameter int unsigned PIXEL_SIZE = fb_scanout_pkg::PIXEL_SIZE,
    parameter int unsigned H_FP       = fb_scanout_pkg::H_FP,
    parameter int unsigned H_SYNC     = fb_scanout_pkg::H_SYNC,
    parameter int unsigned H_BP       = fb_scanout_pkg::H_BP,
    parameter int unsigned V_FP       = fb_scanout_pkg::V_FP,
    parameter int unsigned V_SYNC     = fb_scanout_pkg::V_SYNC,
    parameter int unsigned V_BP       = fb_scanout_pkg::V_BP,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1,
    localparam int unsigned PACKED_SIZE = WIDTH * HEIGHT * PIXEL_SIZE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PACKED_SIZE-1:0] packed_buffer,
    input  logic                   swap_req,
    output logic                   swap_ack,
    output logic [PIXEL_SIZE-1:0]  pixel,
    output logic                   de,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   frame_start
);

    import fb_scanout_pkg::*;

    localparam int unsigned HW    = $clog2(WIDTH + H_FP + H_SYNC + H_BP);
    localparam int unsigned VW    = $clog2(HEIGHT + V_FP + V_SYNC + V_BP);
    localparam int unsigned IDX_W = $clog2(PACKED_SIZE) + 1;

    logic [HW-1:0]         h_cnt;
    logic [VW-1:0]         v_cnt;
    logic                  active, hs_on, vs_on, frame_origin, blank_start;
    logic [IDX_W-1:0]      pix_idx, bit_off;
    logic [PIXEL_SIZE-1:0] pixel_d;

    vga_timing_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_timing (
        .clk          (clk),
        .reset        (reset),
        .h_cnt        (h_cnt),
        .v_cnt        (v_cnt),
        .active       (active),
        .hs_on        (hs_on),
        .vs_on        (vs_on),
        .frame_origin (frame_origin),
        .blank_start  (blank_start)
    );

    // Shift-based select keeps the full-width bit offset without truncation.
    always_comb begin
        pix_idx = IDX_W'(v_cnt) * IDX_W'(WIDTH) + IDX_W'(h_cnt);
        bit_off = pix_idx * IDX_W'(PIXEL_SIZE);
        pixel_d = active ? PIXEL_SIZE'(packed_buffer >> bit_off) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel       <= '0;
            de          <= 1'b0;
            hsync       <= sync_level(1'b0, SYNC_ACTIVE_LOW);
            vsync       <= sync_level(1'b0, SYNC_ACTIVE_LOW);
            frame_start <= 1'b0;
            swap_ack    <= 1'b0;
        end else begin
            pixel       <= pixel_d;
            de          <= active;
            hsync       <= sync_level(hs_on, SYNC_ACTIVE_LOW);
            vsync       <= sync_level(vs_on, SYNC_ACTIVE_LOW);
            frame_start <= frame_origin;
            // blank_start occurs once per frame, so at most one ack per frame.
            swap_ack    <= blank_start & swap_req;
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench for fb_scanout: raster/sync vector table plus reset and swap sequences.
module tb_fb_scanout;

    localparam int PACKED = 16 * 12 * 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              swap_req = 1'b0;
    logic [PACKED-1:0] packed_buffer;
    logic              swap_ack;
    logic [2:0]        pixel;
    logic              de, hsync, vsync, frame_start;

    fb_scanout dut (
        .clk           (clk),
        .reset         (reset),
        .packed_buffer (packed_buffer),
        .swap_req      (swap_req),
        .swap_ack      (swap_ack),
        .pixel         (pixel),
        .de            (de),
        .hsync         (hsync),
        .vsync         (vsync),
        .frame_start   (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        int pix;
        int de;
        int hs;
        int vs;
        int fs;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;
    int   t = -1;  // frame cycle whose counter values the outputs currently show

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk({tag, "_pixel"}, 32'(pixel), 0);
        chk({tag, "_de"}, 32'(de), 0);
        chk({tag, "_hsync"}, 32'(hsync), 1);
        chk({tag, "_vsync"}, 32'(vsync), 1);
        chk({tag, "_ack"}, 32'(swap_ack), 0);
        chk({tag, "_fs"}, 32'(frame_start), 0);
        @(negedge clk);
        reset = 1'b0;
        t = -1;
    endtask

    initial begin
        int n_de, n_hs, n_vs, n_fs, n_ack, j, at;
        int ack_t[$];

        for (int i = 0; i < 192; i++) packed_buffer[i*3 +: 3] = 3'(i % 8);

        //                t    pix de hs vs fs
        vecs.push_back('{   0, 0, 1, 1, 1, 1});
        vecs.push_back('{   1, 1, 1, 1, 1, 0});
        vecs.push_back('{   7, 7, 1, 1, 1, 0});
        vecs.push_back('{   8, 0, 1, 1, 1, 0});
        vecs.push_back('{  15, 7, 1, 1, 1, 0});
        vecs.push_back('{  16, 0, 0, 1, 1, 0});
        vecs.push_back('{  17, 0, 0, 1, 1, 0});
        vecs.push_back('{  18, 0, 0, 0, 1, 0});
        vecs.push_back('{  21, 0, 0, 0, 1, 0});
        vecs.push_back('{  22, 0, 0, 1, 1, 0});
        vecs.push_back('{  24, 0, 1, 1, 1, 0});
        vecs.push_back('{  27, 3, 1, 1, 1, 0});
        vecs.push_back('{ 100, 4, 1, 1, 1, 0});
        vecs.push_back('{ 284, 0, 0, 0, 1, 0});
        vecs.push_back('{ 287, 0, 0, 1, 1, 0});
        vecs.push_back('{ 288, 0, 0, 1, 1, 0});
        vecs.push_back('{ 311, 0, 0, 1, 1, 0});
        vecs.push_back('{ 312, 0, 0, 1, 0, 0});
        vecs.push_back('{ 330, 0, 0, 0, 0, 0});
        vecs.push_back('{ 359, 0, 0, 1, 0, 0});
        vecs.push_back('{ 360, 0, 0, 1, 1, 0});
        vecs.push_back('{ 383, 0, 0, 1, 1, 0});
        vecs.push_back('{ 384, 0, 1, 1, 1, 1});

        // Reset held from time zero
        do_reset("init");

        // First frame: table vectors plus per-frame totals
        n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0; n_ack = 0; j = 0;
        for (int k = 0; k < 400; k++) begin
            step();
            if (t < 384) begin
                n_de += int'(de);
                n_hs += int'(!hsync);
                n_vs += int'(!vsync);
            end
            n_fs  += int'(frame_start);
            n_ack += int'(swap_ack);
            if (j < vecs.size() && vecs[j].t == t) begin
                chk($sformatf("pix@%0d", t), 32'(pixel), vecs[j].pix);
                chk($sformatf("de@%0d", t), 32'(de), vecs[j].de);
                chk($sformatf("hsync@%0d", t), 32'(hsync), vecs[j].hs);
                chk($sformatf("vsync@%0d", t), 32'(vsync), vecs[j].vs);
                chk($sformatf("fs@%0d", t), 32'(frame_start), vecs[j].fs);
                j++;
            end
        end
        chk("vec_coverage", j, vecs.size());
        chk("de_per_frame", n_de, 192);
        chk("hsync_low_per_frame", n_hs, 64);
        chk("vsync_low_per_frame", n_vs, 48);
        chk("frame_starts", n_fs, 2);
        chk("ack_without_req", n_ack, 0);

        // Reset mid-frame at cycle 200, frame_start one clock after release
        do_reset("pre200");
        while (t < 200) step();
        do_reset("mid");
        step();
        chk("fs_after_release", 32'(frame_start), 1);
        chk("de_after_release", 32'(de), 1);
        chk("pix_after_release", 32'(pixel), 0);

        // Early request: one ack at (0,12), then none once req drops
        do_reset("early");
        while (t < 120) step();
        swap_req = 1'b1;
        n_ack = 0; at = -1;
        while (t < 300) begin
            step();
            if (swap_ack) begin
                n_ack++;
                at = t;
                swap_req = 1'b0;
            end
        end
        chk("early_ack_count", n_ack, 1);
        chk("early_ack_time", at, 288);
        n_ack = 0;
        while (t < 288 + 384 + 20) begin
            step();
            n_ack += int'(swap_ack);
        end
        chk("early_no_second_ack", n_ack, 0);

        // Request rising exactly with the counters at (0,12)
        do_reset("simul");
        while (t < 287) step();
        swap_req = 1'b1;
        step();
        chk("simul_ack", 32'(swap_ack), 1);
        swap_req = 1'b0;
        step();
        chk("simul_ack_one_cycle", 32'(swap_ack), 0);

        // Late request held for three frames
        do_reset("late");
        while (t < 291) step();
        swap_req = 1'b1;
        ack_t.delete();
        while (t < 288 + 3 * 384 + 20) begin
            step();
            if (swap_ack) ack_t.push_back(t);
        end
        swap_req = 1'b0;
        chk("late_ack_count", ack_t.size(), 3);
        if (ack_t.size() == 3) begin
            chk("late_first_ack", ack_t[0], 672);
            chk("late_ack_gap1", ack_t[1] - ack_t[0], 384);
            chk("late_ack_gap2", ack_t[2] - ack_t[1], 384);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
